// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic {StRun, StMduBusy} state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic pc_sel_redirect;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_flush;
  } ctrl_t;

  localparam ctrl_t CtrlDefault = '{pc_en: 1'b1, pc_sel_redirect: 1'b0, if_id_en: 1'b1,
                                    if_id_flush: 1'b0, id_ex_en: 1'b1, id_ex_flush: 1'b0,
                                    ex_mem_flush: 1'b0};

  // Front end and ID/EX frozen while a bubble drains out of EX/MEM.
  localparam ctrl_t CtrlMduStall = '{pc_en: 1'b0, pc_sel_redirect: 1'b0, if_id_en: 1'b0,
                                     if_id_flush: 1'b0, id_ex_en: 1'b0, id_ex_flush: 1'b0,
                                     ex_mem_flush: 1'b1};

  localparam ctrl_t CtrlReset = '{pc_en: 1'b0, pc_sel_redirect: 1'b0, if_id_en: 1'b0,
                                  if_id_flush: 1'b1, id_ex_en: 1'b0, id_ex_flush: 1'b1,
                                  ex_mem_flush: 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use detector: an EX load whose destination is a live source of the ID instruction.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       load_use
);

  always_comb begin
    load_use = ex_mem_read && (ex_rd != REG_X0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, redirect, MDU occupancy,
// imem wait states and wrong-path fetch kill.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             ex_mdu_start,
  input  logic             imem_ready,
  output logic             pc_en,
  output logic             pc_sel_redirect,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam bit         MduStalls = (MDU_LAT >= 2);
  localparam logic [4:0] MduInit   = MduStalls ? 5'(MDU_LAT - 2) : 5'd0;

  state_e           state_q, state_d;
  logic             kill_q, kill_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             load_use;
  ctrl_t            ctrl;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  always_comb begin
    ctrl    = CtrlDefault;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StRun: begin
        if (ex_redirect) begin
          ctrl.pc_sel_redirect = 1'b1;
          ctrl.if_id_flush     = 1'b1;
          ctrl.id_ex_flush     = 1'b1;
        end else if (ex_mdu_start && MduStalls) begin
          ctrl    = CtrlMduStall;
          cnt_d   = MduInit;
          state_d = StMduBusy;
        end else if (load_use) begin
          ctrl.pc_en       = 1'b0;
          ctrl.if_id_en    = 1'b0;
          ctrl.id_ex_flush = 1'b1;
        end else if (!imem_ready || kill_q) begin
          // A killed beat counts as a wait state: hold PC, bubble IF/ID.
          ctrl.pc_en       = 1'b0;
          ctrl.if_id_flush = 1'b1;
        end
      end
      StMduBusy: begin
        if (cnt_q != 5'd0) begin
          ctrl  = CtrlMduStall;
          cnt_d = cnt_q - 5'd1;
        end else begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
    if (rst) ctrl = CtrlReset;
  end

  always_comb begin
    kill_d  = !imem_ready && (kill_q || (ex_redirect && (state_q == StRun)));
    stall_d = stall_q;
    if (!ctrl.pc_en && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      kill_q  <= 1'b0;
      cnt_q   <= 5'd0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign pc_en           = ctrl.pc_en;
  assign pc_sel_redirect = ctrl.pc_sel_redirect;
  assign if_id_en        = ctrl.if_id_en;
  assign if_id_flush     = ctrl.if_id_flush;
  assign id_ex_en        = ctrl.id_ex_en;
  assign id_ex_flush     = ctrl.id_ex_flush;
  assign ex_mem_flush    = ctrl.ex_mem_flush;
  assign stall_cycles    = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a default instance (MDU_LAT=4) and an MDU_LAT=1
// instance share the stimulus; a negedge monitor checks both against queued expectations.
module tb_pipe_hazard_ctrl;

  // {pc_en, pc_sel_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush}
  localparam logic [6:0] DEF   = 7'b1010100;
  localparam logic [6:0] REDIR = 7'b1111110;
  localparam logic [6:0] MDU   = 7'b0000001;
  localparam logic [6:0] LU    = 7'b0000110;
  localparam logic [6:0] IMEM  = 7'b0011100;
  localparam logic [6:0] RST   = 7'b0001011;

  typedef struct packed {
    logic [6:0]  e0;
    logic [6:0]  e1;
    logic [31:0] es;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_mem_read = 1'b0;
  logic       ex_redirect = 1'b0, ex_mdu_start = 1'b0, imem_ready = 1'b1;

  logic        pc_en0, sel0, ifen0, iffl0, idexen0, idexfl0, exmemfl0;
  logic        pc_en1, sel1, ifen1, iffl1, idexen1, idexfl1, exmemfl1;
  logic [31:0] stall0, stall1;

  exp_t  sb[$];
  string nq[$];
  logic  chk = 1'b0;
  int    n_cmp = 0;
  int    n_bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MDU_LAT(4), .CNT_W(32)) dut0 (
    .clk (clk), .rst (rst), .id_rs1 (id_rs1), .id_rs2 (id_rs2), .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2), .ex_rd (ex_rd), .ex_mem_read (ex_mem_read),
    .ex_redirect (ex_redirect), .ex_mdu_start (ex_mdu_start), .imem_ready (imem_ready),
    .pc_en (pc_en0), .pc_sel_redirect (sel0), .if_id_en (ifen0), .if_id_flush (iffl0),
    .id_ex_en (idexen0), .id_ex_flush (idexfl0), .ex_mem_flush (exmemfl0),
    .stall_cycles (stall0)
  );

  pipe_hazard_ctrl #(.MDU_LAT(1), .CNT_W(32)) dut1 (
    .clk (clk), .rst (rst), .id_rs1 (id_rs1), .id_rs2 (id_rs2), .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2), .ex_rd (ex_rd), .ex_mem_read (ex_mem_read),
    .ex_redirect (ex_redirect), .ex_mdu_start (ex_mdu_start), .imem_ready (imem_ready),
    .pc_en (pc_en1), .pc_sel_redirect (sel1), .if_id_en (ifen1), .if_id_flush (iffl1),
    .id_ex_en (idexen1), .id_ex_flush (idexfl1), .ex_mem_flush (exmemfl1),
    .stall_cycles (stall1)
  );

  always @(posedge clk) begin
    if (!rst) assert (!(ex_redirect && ex_mdu_start)) else $error("illegal redirect+mdu");
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_underflow: got empty want entry");
      end else begin
        exp_t  e;
        string nm;
        e  = sb.pop_front();
        nm = nq.pop_front();
        check({nm, "_ctrl"},
              {25'd0, pc_en0, sel0, ifen0, iffl0, idexen0, idexfl0, exmemfl0}, {25'd0, e.e0});
        check({nm, "_ctrl_lat1"},
              {25'd0, pc_en1, sel1, ifen1, iffl1, idexen1, idexfl1, exmemfl1}, {25'd0, e.e1});
        check({nm, "_stall_cycles"}, stall0, e.es);
      end
    end
  end

  task automatic vec(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [4:0] rd, input logic mr,
                     input logic redir, input logic mdu, input logic rdy,
                     input logic [6:0] e0, input logic [6:0] e1, input logic [31:0] es,
                     input string nm);
    @(posedge clk);
    #1;
    rst = r; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2; ex_rd = rd;
    ex_mem_read = mr; ex_redirect = redir; ex_mdu_start = mdu; imem_ready = rdy;
    sb.push_back('{e0: e0, e1: e1, es: es});
    nq.push_back(nm);
    chk = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, RST,   RST,   0,  "reset");
    vec(1, 0, 5, 0, 1, 5, 1, 0, 0, 1, RST,   RST,   0,  "reset_hold");
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DEF,   DEF,   0,  "idle");
    vec(0, 0, 5, 0, 1, 5, 1, 0, 0, 1, LU,    LU,    0,  "lu_rs2");
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DEF,   DEF,   1,  "lu_release");
    vec(0, 0, 0, 0, 1, 0, 1, 0, 0, 1, DEF,   DEF,   1,  "lu_x0");
    vec(0, 7, 0, 1, 0, 7, 1, 0, 0, 1, LU,    LU,    1,  "lu_rs1");
    vec(0, 7, 0, 0, 0, 7, 1, 0, 0, 1, DEF,   DEF,   2,  "lu_nouse");
    vec(0, 0, 5, 0, 1, 5, 1, 1, 0, 1, REDIR, REDIR, 2,  "redir_over_lu");
    vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, MDU,   DEF,   2,  "mdu_start");
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, MDU,   DEF,   3,  "mdu_busy1");
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, MDU,   DEF,   4,  "mdu_busy2");
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DEF,   DEF,   5,  "mdu_release");
    vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, MDU,   DEF,   5,  "mdu2_start");
    vec(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, MDU,   REDIR, 6,  "mdu_ign_redir");
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, MDU,   DEF,   7,  "mdu2_busy2");
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DEF,   DEF,   8,  "mdu2_release");
    vec(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, REDIR, REDIR, 8,  "redir_wait");
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IMEM,  IMEM,  8,  "kill_wait");
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, IMEM,  IMEM,  9,  "kill_beat");
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DEF,   DEF,   10, "post_kill");
    for (int i = 0; i < 5; i++) begin
      vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IMEM, IMEM, 32'(10 + i), "imem_wait");
    end
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DEF,   DEF,   15, "imem_done");
    vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, MDU,   DEF,   15, "mdu3_start");
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, MDU,   DEF,   16, "mdu3_busy1");
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, RST,   RST,   0,  "rst_mid_mdu");
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DEF,   DEF,   0,  "post_rst");
    vec(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, REDIR, REDIR, 0,  "redir_pre_rst");
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST,   RST,   0,  "rst_kill");
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DEF,   DEF,   0,  "post_rst_kill");
    vec(0, 3, 0, 1, 0, 3, 1, 0, 0, 0, LU,    LU,    0,  "lu_over_imem");
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DEF,   DEF,   1,  "final");
    @(posedge clk);
    #1;
    chk = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
